// File: rtl/sa_wb_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sa_wb_cache_pkg
// Purpose : Shared types and constants for the set-associative write-back
//           cache: FSM state encoding, metadata bit positions and a helper
//           for sizing way-select fields.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sa_wb_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    // Bit positions inside the 2-bit metadata word written to a way.
    localparam int META_V_BIT = 1;
    localparam int META_D_BIT = 0;

    // A way-select field needs at least one bit even for a direct-mapped build.
    function automatic int way_sel_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_wb_cache_way_array.sv
`default_nettype none
// ============================================================================
// Module  : cache_way_array
// Purpose : Storage for one cache way: valid/dirty bits, tag and line data
//           for every set. Combinational read of the addressed set, one
//           data-word write and one metadata write per cycle.
// Ports   : clk, rst          clock / async active-high reset (V and D only)
//           index_i           set being read and written
//           rd_woff_i         word within the line presented on rdata_o
//           valid_o/dirty_o/tag_o/rdata_o   read-side view of the set
//           data_we_i, wr_woff_i, wr_data_i  data word write
//           meta_we_i, meta_i, meta_tag_i    V/D/TAG write
// Rev     : 1.0  initial release
// ============================================================================
module cache_way_array
    import sa_wb_cache_pkg::*;
#(
    parameter int SETS    = 16,
    parameter int WORDS   = 4,
    parameter int TAG_W   = 24,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = $clog2(SETS),
    parameter int WOFF_W  = $clog2(WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [WOFF_W-1:0]  rd_woff_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [DATA_W-1:0]  rdata_o,
    input  logic               data_we_i,
    input  logic [WOFF_W-1:0]  wr_woff_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               meta_we_i,
    input  logic [1:0]         meta_i,
    input  logic [TAG_W-1:0]   meta_tag_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we_i) begin
            valid_q[index_i] <= meta_i[META_V_BIT];
            dirty_q[index_i] <= meta_i[META_D_BIT];
        end
    end

    // Tag and data arrays carry no reset; V=0 makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (meta_we_i) begin
            tag_q[index_i] <= meta_tag_i;
        end
        if (data_we_i) begin
            data_q[index_i][wr_woff_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign rdata_o = data_q[index_i][rd_woff_i];

endmodule
`default_nettype wire

// File: rtl/sa_wb_cache.sv
`default_nettype none
// ============================================================================
// Module  : sa_wb_cache
// Purpose : N-way set-associative write-back / write-allocate cache with
//           multi-word lines between the CPU and a word-wide memory port.
//           Holds the FSM, beat counter, victim selection and output muxes.
// Ports   : clk, rst                                 clock / async reset
//           cpu_req_addr/valid/wr/wdata              CPU request (IDLE only)
//           cpu_req_data, cpu_req_ready              completion pulse + data
//           mem_req_addr/valid/wr, mem_wr_data       memory beat request
//           mem_req_data, mem_req_ready              refill data / beat done
// Rev     : 1.0  initial release
// ============================================================================
module sa_wb_cache
    import sa_wb_cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_wr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic [DATA_W-1:0] cpu_req_data,
    output logic              cpu_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int WOFF_W  = $clog2(WORDS);
    localparam int TAG_W   = ADDR_W - INDEX_W - WOFF_W - 2;
    localparam int WAY_W   = way_sel_w(WAYS);
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WOFF_W-1:0]   beat_q, beat_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WAY_W-1:0]    vptr_q [SETS];
    logic                vptr_inc;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [WOFF_W-1:0]   req_woff;
    logic                unused_addr_lsb;

    assign req_tag         = addr_q[ADDR_W-1 -: TAG_W];
    assign req_index       = addr_q[2+WOFF_W +: INDEX_W];
    assign req_woff        = addr_q[2 +: WOFF_W];
    assign unused_addr_lsb = ^addr_q[1:0];

    // Per-way views and write controls.
    logic [WAYS-1:0]     way_v, way_d;
    logic [TAG_W-1:0]    way_tag   [WAYS];
    logic [DATA_W-1:0]   way_rdata [WAYS];
    logic [WAYS-1:0]     data_we, meta_we;
    logic [WOFF_W-1:0]   rd_woff, wr_woff;
    logic [DATA_W-1:0]   wr_data;
    logic [1:0]          meta_bits;

    // Writeback walks the victim line; otherwise the requested word is read.
    assign rd_woff = (state_q == ST_WRITEBACK) ? beat_q : req_woff;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .SETS   (SETS),
            .WORDS  (WORDS),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .index_i    (req_index),
            .rd_woff_i  (rd_woff),
            .valid_o    (way_v[w]),
            .dirty_o    (way_d[w]),
            .tag_o      (way_tag[w]),
            .rdata_o    (way_rdata[w]),
            .data_we_i  (data_we[w]),
            .wr_woff_i  (wr_woff),
            .wr_data_i  (wr_data),
            .meta_we_i  (meta_we[w]),
            .meta_i     (meta_bits),
            .meta_tag_i (req_tag)
        );
    end

    // Hit detection and victim choice: lowest invalid way wins, else round robin.
    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, victim_sel;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && way_v[w] && (way_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !way_v[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_sel = inv_found ? inv_way : vptr_q[req_index];
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        beat_d        = beat_q;
        victim_d      = victim_q;
        vptr_inc      = 1'b0;
        data_we       = '0;
        meta_we       = '0;
        wr_woff       = req_woff;
        wr_data       = wdata_q;
        meta_bits     = '0;
        cpu_req_data  = '0;
        cpu_req_ready = 1'b0;
        mem_req_addr  = '0;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        mem_wr_data   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    addr_d  = cpu_req_addr;
                    wr_d    = cpu_req_wr;
                    wdata_d = cpu_req_wdata;
                    state_d = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (hit) begin
                    cpu_req_ready = 1'b1;
                    if (wr_q) begin
                        data_we[hit_way]      = 1'b1;
                        meta_we[hit_way]      = 1'b1;
                        meta_bits[META_V_BIT] = 1'b1;
                        meta_bits[META_D_BIT] = 1'b1;
                    end else begin
                        cpu_req_data = way_rdata[hit_way];
                    end
                    state_d = ST_IDLE;
                end else begin
                    victim_d = victim_sel;
                    beat_d   = '0;
                    state_d  = (way_v[victim_sel] && way_d[victim_sel]) ? ST_WRITEBACK
                                                                        : ST_ALLOCATE;
                end
            end

            ST_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = 1'b1;
                mem_req_addr  = {way_tag[victim_q], req_index, beat_q, 2'b00};
                mem_wr_data   = way_rdata[victim_q];
                if (mem_req_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_ALLOCATE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            ST_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, beat_q, 2'b00};
                if (mem_req_ready) begin
                    data_we[victim_q] = 1'b1;
                    wr_woff           = beat_q;
                    wr_data           = mem_req_data;
                    if (beat_q == LAST_BEAT) begin
                        // Line becomes valid only once fully refilled.
                        meta_we[victim_q]     = 1'b1;
                        meta_bits[META_V_BIT] = 1'b1;
                        vptr_inc              = 1'b1;
                        beat_d                = '0;
                        state_d               = ST_COMPARE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            beat_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                vptr_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            if (vptr_inc) begin
                vptr_q[req_index] <= vptr_q[req_index] + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
